sp1_seq_sub: RTL

SP1_SEQ_SUB -- requirements
Module: sp1_seq_sub

---
 rtl/sp1_seq_sub.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sp1_seq_sub.sv
// Multi-cycle unsigned subtractor: y = (a - b) mod 2^DW, bo = (a < b), computed
// SW bits per clock with a rippled borrow, behind a valid/ready request/response pair.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready; a
// response transfers on a rising edge where rsp_valid && rsp_ready. req_ready and
// rsp_valid are pure decodes of the state register. Operands only matter on the
// transfer edge. y/bo are held from DONE entry until the next DONE entry.
module sp1_seq_sub #(
    parameter int DW = 32,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] y,
    output logic          bo,
    output logic [1:0]    dbg_state
);
    localparam int N  = DW / SW;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] y_q, y_d;
    logic          borrow_q, borrow_d;
    logic          bo_q, bo_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [SW:0]   step_sum;
    logic [SW-1:0] step_diff;
    logic          step_borrow;
    logic [DW-1:0] diff_ext;
    logic [DW-1:0] acc_shift;
    logic          last_step;

    // One SW-bit slice: the extra top bit of the (SW+1)-bit result is the borrow out.
    assign step_sum    = {1'b0, a_q[SW-1:0]} - {1'b0, b_q[SW-1:0]} - {{SW{1'b0}}, borrow_q};
    assign step_diff   = step_sum[SW-1:0];
    assign step_borrow = step_sum[SW];
    assign diff_ext    = DW'(step_diff);
    assign acc_shift   = (acc_q >> SW) | (diff_ext << (DW - SW));
    assign last_step   = (cnt_q == CW'(N - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == DONE);
        y         = y_q;
        bo        = bo_q;
        dbg_state = state_q;
    end

    // Datapath next-state
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        y_d      = y_q;
        borrow_d = borrow_q;
        bo_d     = bo_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d      = a;
                    b_d      = b;
                    acc_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                a_d      = a_q >> SW;
                b_d      = b_q >> SW;
                acc_d    = acc_shift;
                borrow_d = step_borrow;
                cnt_d    = cnt_q + CW'(1);
                // Publish only on completion so y/bo keep the previous result meanwhile.
                if (last_step) begin
                    y_d  = acc_shift;
                    bo_d = step_borrow;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            y_q      <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            y_q      <= y_d;
            borrow_q <= borrow_d;
            bo_q     <= bo_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
